sdram_arbiter: RTL

Shares the single SDRAM controller command port between up to NUM_REQ on-chip masters: CPU instruction fetch, CPU data, VGA scanout and blitter. It grants one requester at a time, latches its command and forwards it to the controller. It then steers read-burst beats and write completions back to the winner. Round-robin between requesters, with optional strict priority for requester 0 (VGA).

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_arbiter_rr_picker.sv | 27 ++
 rtl/sdram_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM command-port arbiter.
// The latched command struct is sized by the package defaults below.
package sdram_arb_pkg;

  localparam int ARB_ADDR_W    = 26;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_BURST_LEN = 8;
  localparam int BEAT_W        = $clog2(ARB_BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] wmask;
  } mem_cmd_t;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    win_o = '0;
    cand  = '0;
    any_o = |req_i;
    for (int off = N; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr_i) + off) % N);
      if (req_i[cand]) win_o = cand;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between NUM_REQ masters (round-robin).
// Define SDRAM_ARB_PRIO0_EN to give requester 0 strict priority over the rotation.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int BURST_LEN = ARB_BURST_LEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_last,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W/8-1:0]      mem_wmask,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_done,
  output logic                     busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int MASK_W = DATA_W / 8;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [CNT_W-1:0]   beat_q;
  logic               burst_done_q;
  mem_cmd_t           cmd_q;
  logic               mem_valid_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_last_q;

  logic [IDX_W-1:0]   rr_win;
  logic               any_valid;
  logic [IDX_W-1:0]   grant_d;
  logic               prio_win_d;
  logic               last_beat;

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .win_o (rr_win),
    .any_o (any_valid)
  );

  // A priority win leaves rr_ptr alone so the others keep their rotation.
  always_comb begin
    grant_d    = rr_win;
    prio_win_d = 1'b0;
`ifdef SDRAM_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_d    = '0;
      prio_win_d = 1'b1;
    end
`else
    prio_win_d = 1'b0;
`endif
  end

  assign last_beat = (beat_q == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      win_q        <= '0;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
      cmd_q        <= '0;
      mem_valid_q  <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            req_ready_q <= NUM_REQ'(1) << grant_d;
            cmd_q.write <= req_write[grant_d];
            cmd_q.addr  <= req_addr[int'(grant_d)*ADDR_W +: ADDR_W];
            cmd_q.wdata <= req_wdata[int'(grant_d)*DATA_W +: DATA_W];
            cmd_q.wmask <= req_wmask[int'(grant_d)*MASK_W +: MASK_W];
            mem_valid_q <= 1'b1;
            win_q       <= grant_d;
            if (!prio_win_d) rr_ptr_q <= grant_d;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // Beats past the burst length are dropped via burst_done_q.
          if (!cmd_q.write && mem_rvalid && !burst_done_q) begin
            rsp_valid_q <= NUM_REQ'(1) << win_q;
            rsp_rdata_q <= mem_rdata;
            rsp_last_q  <= last_beat;
            beat_q      <= beat_q + 1'b1;
            if (last_beat) burst_done_q <= 1'b1;
          end
          if (cmd_q.write && mem_done) begin
            rsp_valid_q <= NUM_REQ'(1) << win_q;
            rsp_last_q  <= 1'b1;
          end
          if (mem_done) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            burst_done_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign mem_valid = mem_valid_q;
  assign mem_write = cmd_q.write;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wmask = cmd_q.wmask;
  assign busy      = (state_q != IDLE);

endmodule
